// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus decode handoff and control.
// master is the fetch unit, slave is the memory/decode environment.
interface instr_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_out;
  logic        lock;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr_out, instr_valid, pc_out, halted,
    input  imem_ack, imem_rdata, instr_ready, lock, redirect, redirect_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_valid, pc_out, halted,
    output imem_ack, imem_rdata, instr_ready, lock, redirect, redirect_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one 16-bit word at a time, hands it to decode,
// follows redirects (draining a stale outstanding request) and stops on opcode 0000.
module instr_fetch (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic        imem_req_r;
  logic [15:0] imem_addr_r;
  logic [15:0] instr_out_r;
  logic        instr_valid_r;
  logic [15:0] pc_out_r;
  logic        halted_r;

  function automatic logic [15:0] pc_inc(input logic [15:0] addr);
    return addr + 16'd2;
  endfunction

  function automatic logic is_halt(input logic [15:0] word);
    return (word[15:12] == 4'b0000);
  endfunction

  // Fetch FSM; imem_addr_r also serves as the held address while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_REQ;
      pc_r          <= 16'h0000;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= 16'h0000;
      instr_out_r   <= 16'h0000;
      instr_valid_r <= 1'b0;
      pc_out_r      <= 16'h0000;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (!imem_req_r) begin
            // First cycle after reset: nothing outstanding, any ack is stale.
            imem_req_r <= 1'b1;
            if (bus.redirect) begin
              pc_r        <= bus.redirect_addr;
              imem_addr_r <= bus.redirect_addr;
            end else begin
              imem_addr_r <= pc_r;
            end
          end else if (bus.redirect) begin
            pc_r <= bus.redirect_addr;
            if (bus.imem_ack) begin
              imem_addr_r <= bus.redirect_addr;
            end else begin
              state_r <= S_DRAIN;
            end
          end else if (bus.imem_ack) begin
            instr_out_r   <= bus.imem_rdata;
            pc_out_r      <= pc_r;
            pc_r          <= pc_inc(pc_r);
            instr_valid_r <= 1'b1;
            imem_req_r    <= 1'b0;
            state_r       <= S_ISSUE;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_ISSUE: begin
          if (bus.redirect) begin
            pc_r          <= bus.redirect_addr;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b1;
            imem_addr_r   <= bus.redirect_addr;
            state_r       <= S_REQ;
          end else if (bus.instr_ready && !bus.lock) begin
            instr_valid_r <= 1'b0;
            if (is_halt(instr_out_r)) begin
              halted_r <= 1'b1;
              state_r  <= S_HALT;
            end else begin
              imem_req_r  <= 1'b1;
              imem_addr_r <= pc_r;
              state_r     <= S_REQ;
            end
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (bus.imem_ack) begin
            state_r <= S_REQ;
            if (bus.redirect) begin
              pc_r        <= bus.redirect_addr;
              imem_addr_r <= bus.redirect_addr;
            end else begin
              imem_addr_r <= pc_r;
            end
          end else if (bus.redirect) begin
            pc_r <= bus.redirect_addr;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_HALT: begin
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
          halted_r      <= 1'b1;
        end
        default: begin
          state_r       <= S_REQ;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_r;
  assign bus.imem_addr   = imem_addr_r;
  assign bus.instr_out   = instr_out_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.pc_out      = pc_out_r;
  assign bus.halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random traffic scored against a
// transaction-level model through a handoff queue.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit rand_on = 1'b0;
  logic [31:0] exp_q[$];
  logic [15:0] seq_w [3] = '{16'hF001, 16'hF004, 16'hF000};

  // Reference model: abstract fetch progress, not the DUT encoding.
  bit          m_start, m_have, m_stale, m_halt;
  logic [15:0] m_pc, m_addr, m_ipc, m_instr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = (a * 16'h9E37) ^ 16'h5A5A;
    if (w[15:12] == 4'h0) w[15:12] = 4'h1;
    return w;
  endfunction

  function automatic logic [31:0] ctl();
    return {13'd0, bus.halted, bus.imem_req, bus.instr_valid, bus.imem_addr};
  endfunction

  function automatic logic [31:0] exp_ctl(input logic h, input logic r, input logic v,
                                          input logic [15:0] a);
    return {13'd0, h, r, v, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 16'h0000;
    bus.instr_ready   = 1'b1;
    bus.lock          = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 16'h0000;
  endtask

  task automatic ack_data(input logic [15:0] d);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
  endtask

  task automatic model_step();
    if (m_halt) return;
    if (m_start) begin
      m_start = 1'b0;
      if (bus.redirect) m_pc = bus.redirect_addr;
      m_addr = m_pc;
    end else if (m_have) begin
      if (bus.redirect) begin
        m_have = 1'b0;
        m_pc   = bus.redirect_addr;
        m_addr = m_pc;
      end else if (bus.instr_ready && !bus.lock) begin
        exp_q.push_back({m_ipc, m_instr});
        m_have = 1'b0;
        if (m_instr[15:12] == 4'h0) m_halt = 1'b1;
        else m_addr = m_pc;
      end
    end else if (bus.imem_ack) begin
      if (m_stale || bus.redirect) begin
        m_stale = 1'b0;
        if (bus.redirect) m_pc = bus.redirect_addr;
        m_addr = m_pc;
      end else begin
        m_have  = 1'b1;
        m_ipc   = m_addr;
        m_instr = mem_word(m_addr);
        m_pc    = m_addr + 16'd2;
      end
    end else if (bus.redirect) begin
      m_pc    = bus.redirect_addr;
      m_stale = 1'b1;
    end
  endtask

  // Scoreboard monitor: every handoff seen on the bus must match the queue head.
  always @(negedge clk) begin
    if (rand_on && rst_n && bus.instr_valid && bus.instr_ready && !bus.lock && !bus.redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handoff: got pc %h instr %h expected none", bus.pc_out, bus.instr_out);
      end else begin
        check("handoff", {bus.pc_out, bus.instr_out}, exp_q.pop_front());
        hs_cnt++;
      end
    end
  end

  initial begin
    logic exp_req;
    idle_inputs();
    #12;
    check("reset_ctl", ctl(), 32'd0);
    check("reset_data", {bus.instr_out, bus.pc_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("start_req", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0000));

    // Sequential fetch, ack one cycle after the request appears.
    for (int i = 0; i < 3; i++) begin
      check("seq_req", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'(2 * i)));
      tick();
      check("seq_hold", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'(2 * i)));
      ack_data(seq_w[i]);
      check("seq_issue", {bus.instr_out, bus.pc_out}, {seq_w[i], 16'(2 * i)});
      check("seq_valid", ctl() & 32'h0007_0000, exp_ctl(1'b0, 1'b0, 1'b1, 16'h0000));
      tick();
    end

    // Halt opcode at 0x0006, then a redirect that must be ignored.
    check("halt_req", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0006));
    ack_data(16'h0123);
    tick();
    check("halt_set", ctl() & 32'h0007_0000, exp_ctl(1'b1, 1'b0, 1'b0, 16'h0000));
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    tick();
    check("halt_sticky", ctl() & 32'h0007_0000, exp_ctl(1'b1, 1'b0, 1'b0, 16'h0000));
    rst_n = 1'b0;
    #1;
    check("halt_reset", ctl(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Lock stall for three cycles with decode ready.
    bus.lock = 1'b1;
    ack_data(16'hC123);
    check("lock_issue", {bus.instr_out, bus.pc_out}, {16'hC123, 16'h0000});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lock_hold", {bus.instr_out, bus.pc_out}, {16'hC123, 16'h0000});
      check("lock_valid", ctl() & 32'h0007_0000, exp_ctl(1'b0, 1'b0, 1'b1, 16'h0000));
    end
    bus.lock = 1'b0;
    tick();
    check("lock_release", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0002));

    for (int j = 0; j < 3; j++) begin
      check("stream_addr", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'(2 + 2 * j)));
      ack_data(16'hE000);
      tick();
    end

    // Redirect while 0x0008 is outstanding; ack two cycles later is drained.
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    check("drain_addr1", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0008));
    tick();
    check("drain_addr2", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0008));
    ack_data(16'hD555);
    check("drain_done", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0100));

    // Redirect with simultaneous ack, wrap at 0xFFFE, redirect beating a halt handoff.
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'hFFFE;
    ack_data(16'h1234);
    bus.redirect = 1'b0;
    check("redir_ack", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'hFFFE));
    ack_data(16'hB000);
    check("wrap_issue", {bus.instr_out, bus.pc_out}, {16'hB000, 16'hFFFE});
    tick();
    check("wrap_addr", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0000));
    ack_data(16'h0000);
    check("zero_issue", {bus.instr_out, bus.pc_out}, 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h0020;
    tick();
    bus.redirect = 1'b0;
    check("redir_beats_halt", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0020));

    // Asynchronous reset while an instruction is held, then a late ack.
    ack_data(16'h7777);
    check("rst_pre", ctl() & 32'h0007_0000, exp_ctl(1'b0, 1'b0, 1'b1, 16'h0000));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", ctl(), 32'd0);
    check("async_rst_data", {bus.instr_out, bus.pc_out}, 32'd0);
    @(negedge clk);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h0000;
    rst_n = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("late_ack", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0000));
    tick();
    check("post_rst_req", ctl(), exp_ctl(1'b0, 1'b1, 1'b0, 16'h0000));

    // Random traffic against the model.
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    m_start = 1'b1; m_have = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
    m_pc = 16'h0000; m_addr = 16'h0000; m_ipc = 16'h0000; m_instr = 16'h0000;
    rst_n = 1'b1;
    model_step();
    rand_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      exp_req = !m_halt && !m_have && !m_start;
      check("rnd_ctl", {29'd0, bus.imem_req, bus.instr_valid, bus.halted},
            {29'd0, exp_req, m_have, m_halt});
      if (exp_req) check("rnd_addr", {16'd0, bus.imem_addr}, {16'd0, m_addr});
      bus.lock        = ($urandom_range(0, 9) < 3);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.redirect    = ($urandom_range(0, 15) == 0);
      if (bus.redirect)
        bus.redirect_addr = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      else
        bus.redirect_addr = 16'h0000;
      if (bus.imem_req) begin
        bus.imem_ack   = ($urandom_range(0, 1) == 1);
        bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 16'h0000;
      end else begin
        bus.imem_ack   = ($urandom_range(0, 15) == 0);
        bus.imem_rdata = 16'h0000;
      end
      model_step();
    end
    tick();
    rand_on = 1'b0;
    idle_inputs();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("handoffs_seen", {31'd0, hs_cnt >= 20}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
